// File: rtl/bus_mux_reg.sv
// rtl/bus_mux_reg.sv - registered one-hot bus mux; lowest enabled index wins, conflicts counted
// Optional macro BUS_PARITY_EN adds src_par input and bus_parity/par_err outputs.
module bus_mux_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 24,
  parameter int KEEP  = 1,
  parameter int CNTW  = 8,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               clr,
`ifdef BUS_PARITY_EN
  input  logic [N-1:0]       src_par,
  output logic               bus_parity,
  output logic               par_err,
`endif
  input  logic [N*WIDTH-1:0] src_data,
  input  logic [N-1:0]       src_out,
  input  logic               err_clr,
  output logic [WIDTH-1:0]   BUS_data,
  output logic               bus_valid,
  output logic [SELW-1:0]    bus_src,
  output logic               conflict,
  output logic               conflict_sticky,
  output logic [CNTW-1:0]    conflict_count
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic             w_any;
  logic             w_multi;
  logic [SELW-1:0]  w_sel;
  logic [WIDTH-1:0] w_sel_data;
`ifdef BUS_PARITY_EN
  logic             w_sel_par;
`endif

  logic [WIDTH-1:0] r_bus;
  logic             r_valid;
  logic [SELW-1:0]  r_src;
  logic             r_conflict;
  logic             r_sticky;
  logic [CNTW-1:0]  r_count;
`ifdef BUS_PARITY_EN
  logic             r_parity;
  logic             r_par_err;
`endif

  // Only a definite 1 counts as a request, so an X enable never selects or flags a conflict.
  always_comb begin
    w_any      = 1'b0;
    w_multi    = 1'b0;
    w_sel      = '0;
    w_sel_data = '0;
`ifdef BUS_PARITY_EN
    w_sel_par  = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      if (src_out[i] == 1'b1) begin
        if (w_any) begin
          w_multi = 1'b1;
        end else begin
          w_sel      = SELW'(i);
          w_sel_data = src_data[i*WIDTH +: WIDTH];
`ifdef BUS_PARITY_EN
          w_sel_par  = src_par[i];
`endif
        end
        w_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_bus      <= '0;
      r_valid    <= 1'b0;
      r_src      <= '0;
      r_conflict <= 1'b0;
      r_sticky   <= 1'b0;
      r_count    <= '0;
`ifdef BUS_PARITY_EN
      r_parity   <= 1'b0;
      r_par_err  <= 1'b0;
`endif
    end else begin
      r_conflict <= w_multi;
      r_valid    <= w_any;
      if (w_any) begin
        r_bus <= w_sel_data;
        r_src <= w_sel;
`ifdef BUS_PARITY_EN
        r_parity  <= ^w_sel_data;
        r_par_err <= w_sel_par ^ (^w_sel_data);
`endif
      end else begin
`ifdef BUS_PARITY_EN
        r_par_err <= 1'b0;
`endif
        if (KEEP == 0) begin
          r_bus <= '0;
`ifdef BUS_PARITY_EN
          r_parity <= 1'b0;
`endif
        end
      end
      // A conflict in the same cycle as err_clr restarts the count at one rather than zero.
      if (w_multi) begin
        r_sticky <= 1'b1;
        if (err_clr) begin
          r_count <= CNTW'(1);
        end else if (r_count != CNT_MAX) begin
          r_count <= r_count + CNTW'(1);
        end
      end else if (err_clr) begin
        r_sticky <= 1'b0;
        r_count  <= '0;
      end
    end
  end

  assign BUS_data        = r_bus;
  assign bus_valid       = r_valid;
  assign bus_src         = r_src;
  assign conflict        = r_conflict;
  assign conflict_sticky = r_sticky;
  assign conflict_count  = r_count;
`ifdef BUS_PARITY_EN
  assign bus_parity      = r_parity;
  assign par_err         = r_par_err;
`endif

endmodule

// File: tb/tb_bus_mux_reg.sv
// tb/tb_bus_mux_reg.sv - directed bench for bus_mux_reg: default build plus KEEP=0/CNTW=2 build
// Compiles with or without BUS_PARITY_EN.
module tb_bus_mux_reg;
  localparam int W = 32;
  localparam int N = 24;
  localparam int S = $clog2(N);

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic [N*W-1:0]   src_data;
  logic [N-1:0]     src_out;
  logic             err_clr;
`ifdef BUS_PARITY_EN
  logic [N-1:0]     src_par = '0;
  logic             d0_par, d0_perr, d1_par, d1_perr;
`endif

  logic [W-1:0] d0_bus, d1_bus;
  logic         d0_valid, d1_valid, d0_conf, d1_conf, d0_sticky, d1_sticky;
  logic [S-1:0] d0_src, d1_src;
  logic [7:0]   d0_cnt;
  logic [1:0]   d1_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bus_mux_reg #(.WIDTH(W), .N(N), .KEEP(1), .CNTW(8)) dut0 (
    .clk(clk), .clr(clr),
`ifdef BUS_PARITY_EN
    .src_par(src_par), .bus_parity(d0_par), .par_err(d0_perr),
`endif
    .src_data(src_data), .src_out(src_out), .err_clr(err_clr),
    .BUS_data(d0_bus), .bus_valid(d0_valid), .bus_src(d0_src),
    .conflict(d0_conf), .conflict_sticky(d0_sticky), .conflict_count(d0_cnt)
  );

  bus_mux_reg #(.WIDTH(W), .N(N), .KEEP(0), .CNTW(2)) dut1 (
    .clk(clk), .clr(clr),
`ifdef BUS_PARITY_EN
    .src_par(src_par), .bus_parity(d1_par), .par_err(d1_perr),
`endif
    .src_data(src_data), .src_out(src_out), .err_clr(err_clr),
    .BUS_data(d1_bus), .bus_valid(d1_valid), .bus_src(d1_src),
    .conflict(d1_conf), .conflict_sticky(d1_sticky), .conflict_count(d1_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 is KEEP=1/count max 255, index 1 is KEEP=0/count max 3.
  logic [W-1:0] m_bus[2]    = '{0, 0};
  logic         m_valid[2]  = '{0, 0};
  logic         m_conf[2]   = '{0, 0};
  logic         m_sticky[2] = '{0, 0};
  logic         m_perr[2]   = '{0, 0};
  int           m_src[2]    = '{0, 0};
  int           m_cnt[2]    = '{0, 0};

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int cmax(input int c);
    return (c == 0) ? 255 : 3;
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int c = 0; c < 2; c++) begin
        m_bus[c] <= '0; m_valid[c] <= 1'b0; m_conf[c] <= 1'b0;
        m_sticky[c] <= 1'b0; m_perr[c] <= 1'b0; m_src[c] <= 0; m_cnt[c] <= 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_valid[c] <= (src_out != '0);
        m_conf[c]  <= ($countones(src_out) > 1);
        if (src_out != '0) begin
          m_bus[c] <= src_data[lowest(src_out)*W +: W];
          m_src[c] <= lowest(src_out);
        end else if (c == 1) begin
          m_bus[c] <= '0;
        end
`ifdef BUS_PARITY_EN
        m_perr[c] <= (src_out != '0) && (src_par[lowest(src_out)] != ^src_data[lowest(src_out)*W +: W]);
`endif
        if ($countones(src_out) > 1) begin
          m_sticky[c] <= 1'b1;
          m_cnt[c] <= err_clr ? 1 : ((m_cnt[c] >= cmax(c)) ? cmax(c) : m_cnt[c] + 1);
        end else if (err_clr) begin
          m_sticky[c] <= 1'b0;
          m_cnt[c] <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("d0_bus", d0_bus, m_bus[0]);
    check("d0_valid", d0_valid, m_valid[0]);
    check("d0_src", d0_src, m_src[0]);
    check("d0_conflict", d0_conf, m_conf[0]);
    check("d0_sticky", d0_sticky, m_sticky[0]);
    check("d0_count", d0_cnt, m_cnt[0]);
    check("d1_bus", d1_bus, m_bus[1]);
    check("d1_valid", d1_valid, m_valid[1]);
    check("d1_src", d1_src, m_src[1]);
    check("d1_conflict", d1_conf, m_conf[1]);
    check("d1_sticky", d1_sticky, m_sticky[1]);
    check("d1_count", d1_cnt, m_cnt[1]);
`ifdef BUS_PARITY_EN
    check("d0_parity", d0_par, ^m_bus[0]);
    check("d1_parity", d1_par, ^m_bus[1]);
    check("d0_par_err", d0_perr, m_perr[0]);
    check("d1_par_err", d1_perr, m_perr[1]);
`endif
  end

  // Called at a falling edge; returns one cycle later when the outputs reflect the inputs.
  task automatic apply(input logic [N-1:0] so, input logic ec);
    src_out = so;
    err_clr = ec;
    @(negedge clk);
  endtask

  logic [N-1:0] conf_v;
  logic [N-1:0] vecs[8];
  int           sat_exp[5];

  initial begin
    vecs    = '{24'h800000, 24'h000001, 24'hFFFFFF, 24'h000000,
                24'hC00000, 24'h000400, 24'h010010, 24'h000000};
    sat_exp = '{1, 2, 3, 3, 3};
    conf_v  = (24'd1 << 3) | (24'd1 << 20);
    err_clr = 1'b1;
    src_out = '1;
    for (int i = 0; i < N; i++) src_data[i*W +: W] = 32'hA5A50000 + i;
    repeat (2) @(negedge clk);
    check("reset_bus", d0_bus, 0);
    check("reset_valid", d0_valid, 0);
    check("reset_count", d0_cnt, 0);
    clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply('0, 1'b0);
      check("idle_bus", d0_bus, 0);
      check("idle_valid", d0_valid, 0);
    end

    src_data[5*W +: W] = 32'hDEADBEEF;
    apply(24'd1 << 5, 1'b0);
    check("load_bus", d0_bus, 32'hDEADBEEF);
    check("load_valid", d0_valid, 1);
    check("load_src", d0_src, 5);
    check("load_conflict", d0_conf, 0);
    for (int k = 0; k < 2; k++) begin
      apply('0, 1'b0);
      check("hold_bus", d0_bus, 32'hDEADBEEF);
      check("hold_valid", d0_valid, 0);
      check("hold_src", d0_src, 5);
      check("nokeep_bus", d1_bus, 0);
    end

    src_data[3*W +: W]  = 32'h11;
    src_data[20*W +: W] = 32'h22;
    apply(conf_v, 1'b0);
    check("conf_bus", d0_bus, 32'h11);
    check("conf_src", d0_src, 3);
    check("conf_flag", d0_conf, 1);
    check("conf_sticky", d0_sticky, 1);
    check("conf_count", d0_cnt, 1);
    apply('0, 1'b0);
    check("conf_pulse", d0_conf, 0);
    check("conf_sticky_hold", d0_sticky, 1);
    apply('0, 1'b1);
    check("clr_count", d0_cnt, 0);
    check("clr_sticky", d0_sticky, 0);

    for (int k = 0; k < 5; k++) begin
      apply(conf_v, 1'b0);
      check("sat_count", d1_cnt, sat_exp[k]);
      check("wide_count", d0_cnt, k + 1);
    end
    apply('0, 1'b1);
    check("sat_clr_count", d1_cnt, 0);
    check("sat_clr_sticky", d1_sticky, 0);
    apply(conf_v, 1'b1);
    check("clr_conf_count", d1_cnt, 1);
    check("clr_conf_sticky", d1_sticky, 1);

    src_data[7*W +: W] = 32'h77777777;
    apply(24'd1 << 7, 1'b0);
    #2 clr = 1'b0;
    #1;
    check("async_bus", d0_bus, 0);
    check("async_valid", d0_valid, 0);
    check("async_src", d0_src, 0);
    check("async_count", d1_cnt, 0);
    #1 clr = 1'b1;
    @(negedge clk);
    check("post_rst_bus", d0_bus, 32'h77777777);
    check("post_rst_src", d0_src, 7);

    for (int i = 0; i < N; i++) src_data[i*W +: W] = 32'hC0DE0000 + i * 32'h00010101;
    for (int k = 0; k < 8; k++) apply(vecs[k], 1'b0);
    src_out = 24'h800000;
    @(negedge clk);
    check("top_src", d0_src, 23);

`ifdef BUS_PARITY_EN
    src_data[0 +: W] = 32'h1;
    src_par = '0;
    apply(24'd1, 1'b0);
    check("par_bus", d0_par, 1);
    check("par_err", d0_perr, 1);
`endif

    apply('0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
